// File: rtl/key_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, press/release
// pulses and a wrapping count of accepted presses.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Key,
    output logic       w,
    output logic       w_press,
    output logic       w_release,
    output logic [7:0] press_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             s2;
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;
    logic             release_reg;
    logic [7:0]       count_reg;

    // Synchronizer chain: stage 0 samples the raw pin, stage 1 is the only
    // copy the FSM ever looks at.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = Key;
            end else begin : g_rest
                assign stage_in = sync_reg[gi-1];
            end
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= stage_in;
                end
            end
        end
    endgenerate

    assign s2 = sync_reg[1];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            count_reg   <= 8'd0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s2) begin
                        state_reg <= PRESS_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= PRESSED;
                        press_reg <= 1'b1;
                        count_reg <= count_reg + 8'd1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state_reg <= RELEASE_WAIT;
                        cnt_reg   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A return to 1 here is release bounce: back to PRESSED silently.
                    if (s2) begin
                        state_reg <= PRESSED;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= IDLE;
                        release_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Debounced level comes straight from state flops, so it cannot glitch.
    assign w           = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);
    assign w_press     = press_reg;
    assign w_release   = release_reg;
    assign press_count = count_reg;
    assign state       = state_reg;

endmodule
